// File: rtl/gpio_in_conditioner.sv
// Pad input conditioner for the AHB GPIO block: synchronise, word-level debounce,
// and append the parity bit that GPIOIN is checked against.
module gpio_in_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pins_in,
    input  logic        parity_sel,
    input  logic        inject_err,
    output logic [16:0] gpioin,
    output logic        gpioin_valid,
    output logic [7:0]  change_cnt
);

    localparam int STAB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][15:0] sync_q;
    logic [15:0]                  sync;

    logic [15:0]       cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [15:0]       data_q, data_d;
    logic              par_q, par_d;
    logic              valid_q, valid_d;
    logic [7:0]        cnt_q, cnt_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // Settling is implied by cand != committed data; no separate state register.
    always_comb begin
        cand_d  = cand_q;
        stab_d  = stab_q;
        data_d  = data_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (sync != cand_q) begin
            cand_d = sync;
            stab_d = '0;
        end else if (cand_q != data_q) begin
            if (stab_q == STAB_LAST) begin
                data_d  = cand_q;
                valid_d = 1'b1;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
        par_d = (^data_d) ^ parity_sel ^ inject_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cand_q  <= '0;
            stab_q  <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pins_in};
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            data_q  <= data_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gpioin       = {par_q, data_q};
    assign gpioin_valid = valid_q;
    assign change_cnt   = cnt_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Scoreboard bench for gpio_in_conditioner at default parameters: expected
// commits are queued when pins are driven and matched against each valid pulse.
module tb_gpio_in_conditioner;

    localparam int LATENCY = 7;   // drive at negedge c -> E0 at posedge c+1 -> commit at posedge c+7

    logic        clk;
    logic        reset;
    logic [15:0] pins_in;
    logic        parity_sel;
    logic        inject_err;
    logic [16:0] gpioin;
    logic        gpioin_valid;
    logic [7:0]  change_cnt;

    gpio_in_conditioner dut (
        .clk          (clk),
        .reset        (reset),
        .pins_in      (pins_in),
        .parity_sel   (parity_sel),
        .inject_err   (inject_err),
        .gpioin       (gpioin),
        .gpioin_valid (gpioin_valid),
        .change_cnt   (change_cnt)
    );

    typedef struct {
        logic [15:0] d;
        logic        p;
        logic [7:0]  cnt;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned n_commits;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [15:0] v, input int unsigned c);
        exp_t e;
        n_commits++;
        e.d   = v;
        e.p   = (^v) ^ parity_sel ^ inject_err;
        e.cnt = (n_commits > 255) ? 8'hFF : 8'(n_commits);
        e.cyc = c + LATENCY;
        exp_q.push_back(e);
    endtask

    task automatic drive_commit(input logic [15:0] v);
        @(negedge clk);
        pins_in = v;
        push_exp(v, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset && gpioin_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(1), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_data",   32'(gpioin[15:0]), 32'(mon_e.d));
                chk("commit_parity", 32'(gpioin[16]),   32'(mon_e.p));
                chk("commit_cnt",    32'(change_cnt),   32'(mon_e.cnt));
                chk("commit_cycle",  32'(cyc),          32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        n_commits  = 0;
        reset      = 1'b1;
        pins_in    = 16'hFFFF;
        parity_sel = 1'b1;
        inject_err = 1'b0;

        // Reset held for 3 edges
        repeat (3) begin
            @(negedge clk);
            chk("rst_gpioin", 32'(gpioin), 32'(0));
            chk("rst_valid",  32'(gpioin_valid), 32'(0));
            chk("rst_cnt",    32'(change_cnt), 32'(0));
        end
        reset = 1'b0;
        push_exp(16'hFFFF, cyc);
        @(negedge clk);
        chk("par_after_rst", 32'(gpioin), 32'(17'h10000));
        wait_cyc(10);
        chk("rst_commit_word", 32'(gpioin), 32'(17'h1FFFF));

        // Basic commit of A5A5 from 0 with even parity
        @(negedge clk);
        parity_sel = 1'b0;
        drive_commit(16'h0000);
        wait_cyc(10);
        drive_commit(16'hA5A5);
        wait_cyc(10);
        chk("basic_word", 32'(gpioin), 32'(17'h0A5A5));
        chk("basic_cnt",  32'(change_cnt), 32'(3));

        // Glitch of 3 cycles from committed 0000
        drive_commit(16'h0000);
        wait_cyc(10);
        @(negedge clk);
        pins_in = 16'h0001;
        wait_cyc(3);
        pins_in = 16'h0000;
        wait_cyc(12);
        chk("glitch_word", 32'(gpioin), 32'(17'h00000));
        chk("glitch_cnt",  32'(change_cnt), 32'(4));

        // Second change two cycles into settling restarts the count
        @(negedge clk);
        pins_in = 16'h0001;
        @(negedge clk);
        drive_commit(16'h0003);
        wait_cyc(10);
        chk("restart_word", 32'(gpioin), 32'(17'h00003));

        // Parity controls on held data 0007
        drive_commit(16'h0007);
        wait_cyc(10);
        chk("par_base", 32'(gpioin), 32'(17'h10007));
        parity_sel = 1'b1;
        @(negedge clk);
        chk("par_sel_odd", 32'(gpioin[16]), 32'(0));
        inject_err = 1'b1;
        @(negedge clk);
        chk("par_inject", 32'(gpioin[16]), 32'(1));
        chk("par_data_held", 32'(gpioin[15:0]), 32'(16'h0007));
        inject_err = 1'b0;
        @(negedge clk);
        chk("par_inject_off", 32'(gpioin[16]), 32'(0));
        chk("par_cnt_held", 32'(change_cnt), 32'(6));

        // 260 distinct commits through saturation, parity_sel varied
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            parity_sel = 1'($urandom_range(0, 1));
            drive_commit(16'h1000 + 16'(i));
            wait_cyc(8);
        end
        wait_cyc(4);
        chk("sat_cnt",  32'(change_cnt), 32'(255));
        chk("sat_word", 32'(gpioin[15:0]), 32'(16'h1103));

        wait_cyc(10);
        chk("pending_commits", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
